// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared loader state encoding and word-format constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Big-endian byte-to-word shift register with a byte counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    localparam int                 CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(BYTES_PER_WORD - 1);

    // Only the first three bytes need storage; the fourth is used as it arrives.
    logic [23:0]      shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_shift) begin
            shift_d = {shift_q[15:0], i_byte};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_word       = {shift_q, i_byte};
    assign o_word_ready = i_shift && !i_clear && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a byte stream into instruction memory as big-endian
//                words while holding the fetch unit in reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int HOLD_EXTRA = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [ADDR_WIDTH:0] WordCount,
    input  logic [7:0]          RxData,
    input  logic                RxValid,
    input  logic                MemReady,
    output logic                MemWrite,
    output logic [31:0]         MemAddress,
    output logic [31:0]         MemWriteData,
    output logic                CpuHold,
    output logic                Busy,
    output logic                Done,
    output logic                Overrun,
    output logic [31:0]         Checksum
);

    localparam logic [ADDR_WIDTH:0] C_MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int                  HOLD_W      = (HOLD_EXTRA > 1) ? $clog2(HOLD_EXTRA) : 1;
    localparam logic [HOLD_W-1:0]   C_HOLD_LAST = HOLD_W'((HOLD_EXTRA > 0) ? HOLD_EXTRA - 1 : 0);

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic [ADDR_WIDTH:0] idx_q, idx_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         csum_q, csum_d;
    logic                ovr_q, ovr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                asm_clear;
    logic                asm_shift;
    logic [31:0]         asm_word;
    logic                asm_ready;
    logic [ADDR_WIDTH:0] idx_inc;

    assign idx_inc = idx_q + 1'b1;

    word_assembler u_asm (
        .clk          (Clk),
        .rst_n        (Reset),
        .i_clear      (asm_clear),
        .i_shift      (asm_shift),
        .i_byte       (RxData),
        .o_word       (asm_word),
        .o_word_ready (asm_ready)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        csum_d    = csum_q;
        ovr_d     = ovr_q;
        hold_d    = hold_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    csum_d    = '0;
                    ovr_d     = 1'b0;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                    if (WordCount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = (WordCount > C_MAX_WORDS) ? C_MAX_WORDS : WordCount;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                asm_shift = RxValid;
                // Capture address and data as the word completes so they stay
                // frozen through the write and afterwards.
                if (asm_ready) begin
                    data_d  = asm_word;
                    addr_d  = 32'({idx_q, 2'b00});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (RxValid) begin
                    ovr_d = 1'b1;
                end
                if (MemReady) begin
                    csum_d  = csum_q ^ data_q;
                    idx_d   = idx_inc;
                    hold_d  = '0;
                    state_d = (idx_inc == count_q) ? S_HOLD : S_COLLECT;
                end
            end
            S_HOLD: begin
                if (hold_q == C_HOLD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            csum_q  <= '0;
            ovr_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
            ovr_q   <= ovr_d;
            hold_q  <= hold_d;
        end
    end

    assign MemWrite     = (state_q == S_WRITE);
    assign MemAddress   = addr_q;
    assign MemWriteData = data_q;
    assign Busy         = (state_q != S_IDLE);
    assign CpuHold      = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign Overrun      = ovr_q;
    assign Checksum     = csum_q;

endmodule
`default_nettype wire
